// File: rtl/b08_feeder_if.sv
// Operand stream, result stream and b08 launch signals of the b08 feeder.
// The slave modport is the feeder itself; master is the environment side.
interface b08_feeder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       start;
  logic [7:0] i;
  logic [3:0] o;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic [7:0] hit_cnt;

  modport master (
    output in_valid, in_data, out_ready, o,
    input  in_ready, start, i, out_valid, out_data, hit_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, o,
    output in_ready, start, i, out_valid, out_data, hit_cnt
  );
endinterface

// File: rtl/b08_feeder.sv
// Buffers operand bytes, launches one b08 evaluation per byte, waits out its
// latency and returns the 4-bit result with a saturating hit counter.
//
// state  | meaning
// IDLE   | waiting for a buffered operand; pops it and raises start
// LAUNCH | start high for this single cycle; loads the wait timer
// WAIT   | timer counting down; captures o at terminal count
// HOLD   | result presented until the consumer takes it
module b08_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_CYC   = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  b08_feeder_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          push, pop;

  logic [4:0]    cnt, cnt_nx;
  logic          start_q, start_nx;
  logic [7:0]    i_q, i_nx;
  logic          ov_q, ov_nx;
  logic [3:0]    od_q, od_nx;
  logic [7:0]    hit_q, hit_nx;

  // No path from in_valid: ready depends on occupancy alone.
  assign bus.in_ready = (count != (PW+1)'(FIFO_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      start_q <= 1'b0;
      i_q     <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      hit_q   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      start_q <= start_nx;
      i_q     <= i_nx;
      ov_q    <= ov_nx;
      od_q    <= od_nx;
      hit_q   <= hit_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    start_nx = 1'b0;
    i_nx     = i_q;
    ov_nx    = ov_q;
    od_nx    = od_q;
    hit_nx   = hit_q;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          i_nx     = mem[rd_ptr];
          start_nx = 1'b1;
          state_nx = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_nx   = 5'(WAIT_CYC);
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == 5'd1) begin
          od_nx    = bus.o;
          ov_nx    = 1'b1;
          if (bus.o != 4'h0 && hit_q != 8'hFF) hit_nx = hit_q + 8'd1;
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt - 5'd1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          ov_nx    = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.start     = start_q;
  assign bus.i         = i_q;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.hit_cnt   = hit_q;
endmodule

// File: tb/tb_b08_feeder.sv
// Scoreboard bench for b08_feeder with a timing-accurate stand-in for the b08
// matcher (start sampled at A+1, operand at A+2, result updated at A+18).
module tb_b08_feeder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  b08_feeder_if bus();

  b08_feeder #(.FIFO_DEPTH(4), .WAIT_CYC(18)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         push_cyc;
  logic [7:0] exp_hits = 8'd0;
  logic [11:0] exp_q[$];
  int         rise_q[$];
  int         start_pulses = 0;
  int         last_start_cyc = -1;
  int         xfers = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in result mapping; 0x00 -> F and 0xFF -> E match the real matcher.
  function automatic logic [3:0] b08_ref(input logic [7:0] d);
    if (d == 8'h00) return 4'hF;
    if (d == 8'hFF) return 4'hE;
    return d[3:0] ^ d[7:4];
  endfunction

  logic [4:0] mcnt;
  logic [7:0] mlat;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt  <= 5'd0;
      mlat  <= 8'd0;
      bus.o <= 4'd0;
    end else if (bus.start) begin
      mcnt <= 5'd1;
    end else if (mcnt != 5'd0) begin
      if (mcnt == 5'd1) mlat <= bus.i;
      if (mcnt == 5'd17) begin
        bus.o <= b08_ref(mlat);
        mcnt  <= 5'd0;
      end else begin
        mcnt <= mcnt + 5'd1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic        prev_start = 1'b0, prev_ov = 1'b0, prev_ordy = 1'b0;
  logic [3:0]  prev_data = 4'd0;
  logic [11:0] mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.start) begin
        start_pulses++;
        last_start_cyc = cyc;
        chk("start_width", int'(prev_start), 0);
      end
      if (bus.out_valid && !prev_ov) rise_q.push_back(cyc);
      if (prev_ov && !prev_ordy && bus.out_valid)
        chk("hold_stable", int'(bus.out_data), int'(prev_data));
      if (bus.out_valid && bus.out_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected none", bus.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", int'(bus.out_data), int'(mon_e[11:8]));
          chk("hit_cnt", int'(bus.hit_cnt), int'(mon_e[7:0]));
        end
      end
    end
    prev_start = bus.start;
    prev_ov    = bus.out_valid;
    prev_ordy  = bus.out_ready;
    prev_data  = bus.out_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] r);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("push_timeout", int'(n >= 100), 0);
    tick();
    push_cyc = cyc;
    if (r != 4'h0 && exp_hits != 8'hFF) exp_hits++;
    exp_q.push_back({r, exp_hits});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 600) begin
      tick();
      n++;
    end
    chk("drain_timeout", int'(n >= 600), 0);
  endtask

  task automatic wait_rise(input int want);
    int n;
    n = 0;
    while (rise_q.size() < want && n < 200) begin
      tick();
      n++;
    end
    chk("rise_timeout", int'(n >= 200), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
    chk({tag, "_start"}, int'(bus.start), 0);
    chk({tag, "_i"}, int'(bus.i), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_data"}, int'(bus.out_data), 0);
    chk({tag, "_hit_cnt"}, int'(bus.hit_cnt), 0);
  endtask

  int s0, x0, r0, p;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    #12 check_reset("por");
    #11 rst_n = 1'b1;
    tick();

    // Idle: no launches without input.
    s0 = start_pulses;
    repeat (50) tick();
    chk("idle_no_start", start_pulses - s0, 0);

    // Single operand: start at P+1, out_valid at P+20.
    rise_q.delete();
    s0 = start_pulses;
    push(8'h00, 4'hF);
    bus.in_valid = 1'b0;
    p = push_cyc;
    wait_drain();
    chk("single_start_pulses", start_pulses - s0, 1);
    chk("single_start_cycle", last_start_cyc, p + 1);
    chk("single_rises", rise_q.size(), 1);
    if (rise_q.size() >= 1) chk("single_valid_cycle", rise_q[0], p + 20);

    // Reset mid-simulation while idle with a nonzero hit count.
    rst_n = 1'b0;
    #2 check_reset("mid");
    exp_q.delete();
    exp_hits = 8'd0;
    #2 rst_n = 1'b1;
    tick();

    // Back-to-back operands, 21 cycles apart.
    rise_q.delete();
    push(8'h00, 4'hF);
    p = push_cyc;
    push(8'hFF, 4'hE);
    bus.in_valid = 1'b0;
    wait_drain();
    chk("b2b_rises", rise_q.size(), 2);
    if (rise_q.size() >= 2) begin
      chk("b2b_first_cycle", rise_q[0], p + 20);
      chk("b2b_spacing", rise_q[1] - rise_q[0], 21);
    end
    chk("b2b_hit_cnt", int'(bus.hit_cnt), 2);

    // FIFO full under output backpressure: 5 accepted, extras refused.
    bus.out_ready = 1'b0;
    rise_q.delete();
    s0 = start_pulses;
    x0 = xfers;
    push(8'h12, 4'h3);
    push(8'h55, 4'h0);
    push(8'hA3, 4'h9);
    push(8'h3C, 4'hF);
    push(8'h00, 4'hF);
    chk("full_in_ready", int'(bus.in_ready), 0);
    bus.in_data = 8'h77;
    repeat (8) begin
      tick();
      chk("full_refuse", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    repeat (30) tick();
    chk("full_single_launch", start_pulses - s0, 1);
    bus.out_ready = 1'b1;
    wait_drain();
    repeat (30) tick();
    chk("full_transfers", xfers - x0, 5);
    chk("full_hit_cnt", int'(bus.hit_cnt), 6);

    // Output backpressure for 40 cycles.
    bus.out_ready = 1'b0;
    rise_q.delete();
    push(8'hFF, 4'hE);
    bus.in_valid = 1'b0;
    wait_rise(1);
    s0 = start_pulses;
    x0 = xfers;
    repeat (40) tick();
    chk("bp_no_start", start_pulses - s0, 0);
    chk("bp_no_xfer", xfers - x0, 0);
    chk("bp_valid_held", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    wait_drain();
    chk("bp_one_xfer", xfers - x0, 1);

    // Reset while the wait timer holds 9 (edge A+10, A = P+1).
    rise_q.delete();
    push(8'h12, 4'h3);
    bus.in_valid = 1'b0;
    p = push_cyc;
    while (cyc < p + 11) tick();
    chk("rw_in_wait", int'(bus.start) + int'(bus.out_valid), 0);
    rst_n = 1'b0;
    #1 check_reset("rw");
    exp_q.delete();
    exp_hits = 8'd0;
    r0 = rise_q.size();
    #2 rst_n = 1'b1;
    repeat (40) tick();
    chk("rw_no_rise", rise_q.size() - r0, 0);
    chk("rw_out_valid", int'(bus.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/b08_feeder.md
# b08_feeder

Host-side sequencer that sits directly upstream and downstream of the b08 ROM-pattern matcher. It accepts 8-bit operands over a valid/ready stream and buffers them in a small FIFO. It launches one b08 evaluation per operand by driving `START`/`I`, waits out the matcher's fixed latency, and returns the matcher's 4-bit `O` result over a second valid/ready stream, together with a saturating hit counter.

## Interface
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, minimum 2.
- `WAIT_CYC`, 18: cycles from the LAUNCH→WAIT edge to the capture edge; must be ≥18.
- `CLOCK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `IN_VALID` in 1: operand offered.
- `IN_DATA` in 8: operand byte.
- `IN_READY` out 1: FIFO not full; a push occurs on edge when `IN_VALID & IN_READY`.
- `START` out 1: to b08 `START`; one-cycle pulse per launch.
- `I` out 8: to b08 `I`; last launched operand, held until next launch.
- `O` in 4: from b08 `O`.
- `OUT_VALID` out 1: result available.
- `OUT_DATA` out 4: captured `O`.
- `OUT_READY` in 1: consumer accepts; transfer on edge when `OUT_VALID & OUT_READY`.
- `HIT_CNT` out 8: number of results with `OUT_DATA != 0`, saturates at 255.

## Operation
- FIFO: circular buffer with read pointer, write pointer, and an occupancy count of width log2(FIFO_DEPTH)+1. There is no bypass; a byte pushed while the FIFO is empty is popped at the earliest on the following edge. Push and pop can occur on the same edge; when that happens the count is unchanged. When full, `IN_READY`=0 and `IN_VALID` is ignored.
- FSM states and transitions:
  - IDLE: if FIFO is non-empty, pop the head, `I`<=head, `START`<=1, go to LAUNCH. Otherwise stay.
  - LAUNCH: `START`<=0, `cnt`<=`WAIT_CYC`, go to WAIT.
  - WAIT: if `cnt`==1, `OUT_DATA`<=`O`, `OUT_VALID`<=1, increment `HIT_CNT` if `O`!=0 (saturating), go to HOLD. Otherwise `cnt`<=`cnt`-1.
  - HOLD: if `OUT_READY`, `OUT_VALID`<=0 and go to IDLE. Otherwise hold `OUT_DATA` stable.
- `cnt` is 5 bits wide and never wraps. `START` is high only while in LAUNCH.
- `OUT_DATA` retains its last value after the handshake completes.
- Asynchronous reset (`RESET`=0), at any point including mid-WAIT:
  - state IDLE; FIFO emptied.
  - `START`=0, `I`=0x00, `OUT_VALID`=0, `OUT_DATA`=0x0, `HIT_CNT`=0, `cnt`=0.
  - `IN_READY`=1, since the FIFO is empty.
  - b08 shares this reset net, so no in-flight evaluation survives.

## Timing
- Let edge A be the IDLE→LAUNCH edge.
  - b08 samples `START`=1 at A+1 and samples `I` at A+2.
  - b08 updates `O` at A+18.
  - Feeder captures at A+1+`WAIT_CYC` (A+19 by default), so `OUT_VALID` rises after A+19.
- `START` width is exactly one cycle. It is low again before b08 reaches its final the_end check, so b08 writes `O` and returns to its start state without relaunching.
- Minimum per-operand period is `WAIT_CYC`+3 cycles (21 by default) with `OUT_READY` held high. Backpressure on the output stalls in HOLD; no further launch is issued until the result is accepted.
- `IN_READY` is combinational from the occupancy count only, with no combinational path from `IN_VALID`. All other outputs are registered.

## Test plan
- Reset and idle:
  - Drive `RESET`=0 mid-simulation, then release. Require all outputs at their reset values and `IN_READY`=1.
  - With no input for 50 cycles, require `START` to stay 0.
- Single operand, paired with b08:
  - Push 0x00 at edge P. Require `START` high for exactly one cycle at P+1 and `OUT_VALID` rising 20 cycles after P.
  - Require `OUT_DATA`=0xF and `HIT_CNT`=1.
- Back-to-back operands:
  - Push 0x00 then 0xFF on consecutive edges with `OUT_READY`=1.
  - Require results 0xF then 0xE, in order, 21 cycles apart, with `HIT_CNT`=2.
- FIFO full:
  - Hold `OUT_READY`=0 and push 6 bytes.
  - Require `IN_READY`=0 after 4 are buffered, with the extra bytes not accepted. This holds because the first byte is popped into the launch path, which frees one slot.
  - Release `OUT_READY` and require every accepted byte to produce exactly one result, in order.
- Output backpressure:
  - Hold `OUT_READY`=0 for 40 cycles after `OUT_VALID` rises. Require `OUT_DATA` stable, no second `START` pulse, and exactly one transfer once `OUT_READY`=1.
- Reset mid-WAIT:
  - Assert `RESET`=0 while `cnt`=9. Require immediate reset values.
  - After release with the FIFO empty, require no `OUT_VALID`.
